// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: one-deep stereo holding register feeding an I2S transmitter
// (SCLK and LRCLK generated from clk, 1-bit I2S data delay, MSB first).
// Latency: a held pair is committed at the next frame wrap and its left MSB
// appears on SDout one SCLK period after LRCLK falls.
// Backpressure: in_rdy is low while the holding register is full. in_vld
// presented while in_rdy is low is dropped, not queued.
//
// Ports:
//   clk, rst          system clock; synchronous active-high reset
//   lft_in, rht_in    stereo sample pair from the core (DATA_W each)
//   in_vld, in_rdy    valid/ready handshake into the holding register
//   err_clr           clears the sticky underrun flag
//   SCLK, LRCLK       I2S bit clock and word select (0 = left, 1 = right)
//   SDout             I2S serial data
//   frame_strb        one-clk pulse when a held pair is committed to the frame regs
//   underrun          sticky: a frame boundary was reached with nothing held
//
// Build option I2S_UNDERRUN_MUTE_EN: when defined, an underrun frame is muted
// (frame regs cleared). When undefined, the previous pair is repeated.

module i2s_tx_serializer #(
  parameter int DATA_W   = 16,
  parameter int SLOT_W   = 32,
  parameter int SCLK_DIV = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] lft_in,
  input  logic [DATA_W-1:0] rht_in,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic              err_clr,
  output logic              SCLK,
  output logic              LRCLK,
  output logic              SDout,
  output logic              frame_strb,
  output logic              underrun
);

  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_W);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] L_FIRST  = BIT_W'(1);
  localparam logic [BIT_W-1:0] L_LAST   = BIT_W'(DATA_W);
  localparam logic [BIT_W-1:0] R_FIRST  = BIT_W'(SLOT_W + 1);
  localparam logic [BIT_W-1:0] R_LAST   = BIT_W'(SLOT_W + DATA_W);
  localparam logic [BIT_W-1:0] R_START  = BIT_W'(SLOT_W);

  // Prescaler and bit position state
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;

  // Holding register (one pair deep) and the pair currently on the wire
  logic              hold_full;
  logic [DATA_W-1:0] hold_l;
  logic [DATA_W-1:0] hold_r;
  logic [DATA_W-1:0] frm_l;
  logic [DATA_W-1:0] frm_r;

  // Event decode
  logic              div_wrap;
  logic              fall_evt;
  logic              frame_wrap;
  logic              load_ok;
  logic              load_ur;
  logic              xfer;
  logic [BIT_W-1:0]  bit_nxt;
  logic [IDX_W-1:0]  l_idx;
  logic [IDX_W-1:0]  r_idx;
  logic              sd_nxt;

  assign in_rdy = ~hold_full;

  always_comb begin
    div_wrap   = (div_cnt == DIV_LAST);
    // SCLK is about to go 1 -> 0: every SCLK-domain register advances here
    fall_evt   = div_wrap & SCLK;
    frame_wrap = fall_evt & (bit_cnt == BIT_LAST);
    load_ok    = frame_wrap & hold_full;
    load_ur    = frame_wrap & ~hold_full;
    // Only accepted while empty; an in_vld against a full register is dropped
    xfer       = in_vld & ~hold_full;
    bit_nxt    = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
  end

  // Serial bit for the upcoming bit position. The one-bit I2S delay puts the
  // MSB at position 1 of each slot; position 0 and the slot tail are zero.
  always_comb begin
    sd_nxt = 1'b0;
    l_idx  = IDX_W'(DATA_W - int'(bit_nxt));
    r_idx  = IDX_W'(SLOT_W + DATA_W - int'(bit_nxt));
    if (bit_nxt >= L_FIRST && bit_nxt <= L_LAST) begin
      sd_nxt = frm_l[l_idx];
    end else if (bit_nxt >= R_FIRST && bit_nxt <= R_LAST) begin
      sd_nxt = frm_r[r_idx];
    end
  end

  // Prescaler: SCLK toggles once every SCLK_DIV clk cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      SCLK    <= 1'b0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      if (div_wrap) begin
        SCLK <= ~SCLK;
      end
    end
  end

  // Bit position, word select and data all move on the SCLK falling edge
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      LRCLK   <= 1'b0;
      SDout   <= 1'b0;
    end else if (fall_evt) begin
      bit_cnt <= bit_nxt;
      LRCLK   <= (bit_nxt >= R_START);
      SDout   <= sd_nxt;
    end
  end

  // Holding register. xfer and load_ok are mutually exclusive (empty vs full),
  // so a pair arriving on an underrun wrap is simply captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
    end else if (xfer) begin
      hold_full <= 1'b1;
      hold_l    <= lft_in;
      hold_r    <= rht_in;
    end else if (load_ok) begin
      hold_full <= 1'b0;
    end
  end

  // Frame registers: committed at the frame wrap. The bit sent on the wrap
  // itself is position 0 (always zero), so the new pair is in place in time.
  always_ff @(posedge clk) begin
    if (rst) begin
      frm_l <= '0;
      frm_r <= '0;
    end else if (load_ok) begin
      frm_l <= hold_l;
      frm_r <= hold_r;
`ifdef I2S_UNDERRUN_MUTE_EN
    end else if (load_ur) begin
      frm_l <= '0;
      frm_r <= '0;
`endif
    end
    // Without muting an underrun leaves the frame regs alone: the last pair repeats.
  end

  // Strobe and sticky underrun; a new underrun beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_strb <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_strb <= load_ok;
      if (load_ur) begin
        underrun <= 1'b1;
      end else if (err_clr) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
module tb_i2s_tx_serializer;

  localparam int DATA_W   = 16;
  localparam int SLOT_W   = 32;
  localparam int SCLK_DIV = 16;
  localparam int BITP     = 2 * SCLK_DIV;        // clk per SCLK period
  localparam int FRAME    = 2 * SLOT_W * BITP;   // clk per LRCLK period

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] lft_in;
  logic [DATA_W-1:0] rht_in;
  logic              in_vld;
  logic              in_rdy;
  logic              err_clr;
  logic              SCLK;
  logic              LRCLK;
  logic              SDout;
  logic              frame_strb;
  logic              underrun;

  always #5 clk = ~clk;

  i2s_tx_serializer #(
    .DATA_W  (DATA_W),
    .SLOT_W  (SLOT_W),
    .SCLK_DIV(SCLK_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lft_in    (lft_in),
    .rht_in    (rht_in),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .err_clr   (err_clr),
    .SCLK      (SCLK),
    .LRCLK     (LRCLK),
    .SDout     (SDout),
    .frame_strb(frame_strb),
    .underrun  (underrun)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
  endtask

  // ---------------- reference model ----------------
  // Timing is derived from the clk count since reset: SCLK half-periods,
  // bit slots and frame boundaries are plain divisions of that count.
  bit                m_valid = 1'b0;
  int                cyc = 0;
  int                k;
  bit                rdy_before;
  bit                m_set;
  bit                m_hold_full, m_ur, m_sclk, m_lr, m_sd, m_strb;
  logic [DATA_W-1:0] m_hold_l, m_hold_r, m_frm_l, m_frm_r, m_tmp;
  logic [31:0]       exp_q[$];

  // I2S receiver state
  bit                d_prev_sclk, d_prev_lr, d_tail, d_tail_l;
  int                d_pos;
  logic [DATA_W-1:0] d_smp, d_left;
  bit                saw_dropped = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid     = 1'b1;
      cyc         = 0;
      m_hold_full = 1'b0;
      m_hold_l    = '0;
      m_hold_r    = '0;
      m_frm_l     = '0;
      m_frm_r     = '0;
      m_ur        = 1'b0;
      m_sclk      = 1'b0;
      m_lr        = 1'b0;
      m_sd        = 1'b0;
      m_strb      = 1'b0;
      exp_q.delete();
      exp_q.push_back(32'h0);   // the first frame after reset carries zeros
      d_prev_sclk = 1'b0;
      d_prev_lr   = 1'b1;       // so the first sampled bit opens a left slot
      d_pos       = 0;
      d_smp       = '0;
      d_left      = '0;
      d_tail      = 1'b0;
      d_tail_l    = 1'b0;
    end else if (m_valid) begin
      cyc++;
      rdy_before = !m_hold_full;
      m_strb     = 1'b0;
      m_set      = 1'b0;
      if (cyc % FRAME == 0) begin
        if (m_hold_full) begin
          m_frm_l     = m_hold_l;
          m_frm_r     = m_hold_r;
          m_hold_full = 1'b0;
          m_strb      = 1'b1;
        end else begin
          m_set = 1'b1;
`ifdef I2S_UNDERRUN_MUTE_EN
          m_frm_l = '0;
          m_frm_r = '0;
`endif
        end
        exp_q.push_back({m_frm_l, m_frm_r});
      end
      if (in_vld && rdy_before) begin
        m_hold_l    = lft_in;
        m_hold_r    = rht_in;
        m_hold_full = 1'b1;
      end
      if (m_set) m_ur = 1'b1;
      else if (err_clr) m_ur = 1'b0;
      m_sclk = ((cyc / SCLK_DIV) % 2) == 1;
      if (cyc % BITP == 0) begin
        k    = (cyc / BITP) % (2 * SLOT_W);
        m_lr = (k >= SLOT_W);
        if (k >= 1 && k <= DATA_W) begin
          m_tmp = m_frm_l >> (DATA_W - k);
          m_sd  = m_tmp[0];
        end else if (k >= SLOT_W + 1 && k <= SLOT_W + DATA_W) begin
          m_tmp = m_frm_r >> (SLOT_W + DATA_W - k);
          m_sd  = m_tmp[0];
        end else begin
          m_sd = 1'b0;
        end
      end
    end
  end

  // Per-cycle output comparison plus an independent I2S receiver that decodes
  // SDout on SCLK rising edges and checks each frame against the model queue.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("outs", {SCLK, LRCLK, SDout, frame_strb, underrun, in_rdy},
          {m_sclk, m_lr, m_sd, m_strb, m_ur, !m_hold_full});
      if (SCLK && !d_prev_sclk) begin
        if (LRCLK != d_prev_lr) d_pos = 0;
        else d_pos++;
        d_prev_lr = LRCLK;
        if (d_pos >= 1 && d_pos <= DATA_W) d_smp = {d_smp[DATA_W-2:0], SDout};
        else d_tail = d_tail | SDout;
        if (d_pos == SLOT_W - 1) begin
          if (!LRCLK) begin
            d_left   = d_smp;
            d_tail_l = d_tail;
          end else begin
            chk("slot_pad", {d_tail_l, d_tail}, 2'b00);
            if ({d_left, d_smp} == 32'h1111_2222) saw_dropped = 1'b1;
            if (exp_q.size() == 0) chk("frame_q", exp_q.size(), 1);
            else chk("frame", {d_left, d_smp}, exp_q.pop_front());
          end
          d_tail = 1'b0;
          d_smp  = '0;
        end
      end
      d_prev_sclk = SCLK;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wait_wrap();
    wait_cyc((cyc / FRAME + 1) * FRAME + 1);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic send_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    int w;
    w = 0;
    while (!in_rdy && w < 3 * FRAME) begin
      @(negedge clk);
      w++;
    end
    if (!in_rdy) begin
      chk("rdy_timeout", in_rdy, 1'b1);
    end else begin
      lft_in = l;
      rht_in = r;
      in_vld = 1'b1;
      @(negedge clk);
      in_vld = 1'b0;
    end
  endtask

  task automatic check_start_timing();
    wait_cyc(31);   chk("sclk_hi_31", SCLK, 1'b1);
    wait_cyc(32);   chk("sclk_fall_32", SCLK, 1'b0);
    wait_cyc(1023); chk("lr_lo_1023", LRCLK, 1'b0);
    wait_cyc(1024); chk("lr_rise_1024", LRCLK, 1'b1);
  endtask

  logic [15:0] base_l, base_r;
  int          w, target;

  initial begin
    rst = 1'b1; lft_in = '0; rht_in = '0; in_vld = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_outs", {SCLK, LRCLK, SDout, frame_strb, underrun, in_rdy}, 6'b000001);

    // Idle after reset: zero frame, underrun at the first wrap
    check_start_timing();
    wait_cyc(2047); chk("ur_pre_wrap", underrun, 1'b0);
    wait_cyc(2048); chk("ur_first_wrap", underrun, 1'b1);
    wait_cyc(2100);
    pulse_clr();
    chk("ur_clear", underrun, 1'b0);

    // Back-to-back: one pair per frame, incrementing values
    base_l = 16'($urandom);
    base_r = 16'($urandom);
    for (int i = 0; i < 8; i++) send_pair(base_l + 16'(i), base_r + 16'(i));
    wait_wrap();
    chk("ur_b2b", underrun, 1'b0);

    // Second pair while held is dropped
    send_pair(16'h0F0F, 16'hF0F0);
    chk("rdy_after_xfer", in_rdy, 1'b0);
    lft_in = 16'h1111; rht_in = 16'h2222; in_vld = 1'b1;
    repeat (4) @(negedge clk);
    in_vld = 1'b0;
    wait_wrap();
    wait_wrap();
    pulse_clr();

    // Starve after 7FFF/8000
    send_pair(16'h7FFF, 16'h8000);
    wait_wrap();
    wait_wrap();
    chk("ur_starve", underrun, 1'b1);
    target = (cyc / FRAME + 1) * FRAME;
    wait_cyc(target - 1);
    err_clr = 1'b1;               // clear lands on the underrun wrap edge
    @(negedge clk);
    err_clr = 1'b0;
    chk("ur_set_wins", underrun, 1'b1);
    wait_cyc(cyc + 10);
    pulse_clr();
    chk("ur_clr_mid", underrun, 1'b0);

    // Randomized traffic and error clears
    for (int i = 0; i < 12000; i++) begin
      in_vld  = ($urandom_range(0, 1499) == 0);
      lft_in  = 16'($urandom);
      rht_in  = 16'($urandom);
      err_clr = ($urandom_range(0, 799) == 0);
      @(negedge clk);
    end
    in_vld = 1'b0; err_clr = 1'b0;

    // Reset for one clk in the middle of a right slot
    w = 0;
    while (!LRCLK && w < 2 * FRAME) begin
      @(negedge clk);
      w++;
    end
    chk("lr_seen", LRCLK, 1'b1);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_outs", {SCLK, LRCLK, SDout, frame_strb, underrun, in_rdy}, 6'b000001);
    wait_cyc(20);
    check_start_timing();
    send_pair(16'hA5C3, 16'h8001);
    wait_cyc(2047); chk("strb_2047", frame_strb, 1'b0);
    wait_cyc(2048); chk("strb_2048", frame_strb, 1'b1);
    chk("ur_2048_loaded", underrun, 1'b0);
    wait_cyc(2049); chk("strb_2049", frame_strb, 1'b0);
    wait_cyc(4100);
    chk("q_pending", exp_q.size(), 1);
    chk("dropped_tx", saw_dropped, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
